// File: rtl/bcd_seg_pkg.sv
// Shared types and constants for the BCD scan display: conversion FSM states,
// 7-segment codes and the double-dabble nibble adjust helper.
package bcd_seg_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } conv_state_e;

  localparam int unsigned SHIFT_CNT = 8;

  // Digit code routed through the decoder to select the carry dash.
  localparam logic [3:0] DIGIT_DASH = 4'hA;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [11:0] dabble_adjust(input logic [11:0] bcd);
    logic [11:0] res;
    res = bcd;
    for (int i = 0; i < 3; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit-to-segment decoder (gfedcba, active-high) with blank override.
module seg7_decode
  import bcd_seg_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i) begin
      unique case (digit_i)
        4'd0:       seg_o = SEG_0;
        4'd1:       seg_o = SEG_1;
        4'd2:       seg_o = SEG_2;
        4'd3:       seg_o = SEG_3;
        4'd4:       seg_o = SEG_4;
        4'd5:       seg_o = SEG_5;
        4'd6:       seg_o = SEG_6;
        4'd7:       seg_o = SEG_7;
        4'd8:       seg_o = SEG_8;
        4'd9:       seg_o = SEG_9;
        DIGIT_DASH: seg_o = SEG_DASH;
        default:    seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/bcd_seg_scan.sv
// Samples an 8-bit count, converts it to BCD with a sequential double-dabble engine and
// scans ones/tens/hundreds plus a carry dash onto a 4-digit multiplexed 7-segment display.
module bcd_seg_scan
  import bcd_seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000,
  parameter bit          LZB      = 1'b1
) (
  input  logic       clk,
  input  logic       mr,
  input  logic [7:0] q_in,
  input  logic       co_in,
  output logic [6:0] seg,
  output logic [3:0] dig_sel,
  output logic       conv_done
);

  localparam int unsigned    PreW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(SCAN_DIV - 1);

  conv_state_e state_q;
  logic [7:0]  sh_q;
  logic [11:0] bcd_q;
  logic [11:0] bcd_adj;
  logic        co_s_q;
  logic [2:0]  cnt_q;
  logic [11:0] disp_bcd_q;
  logic        disp_co_q;
  logic        conv_done_q;

  logic [PreW-1:0] pre_q;
  logic [1:0]      idx_q;
  logic [6:0]      seg_q;
  logic [6:0]      seg_d;
  logic [3:0]      dig_sel_q;
  logic [3:0]      digit;
  logic            blank;

  assign bcd_adj = dabble_adjust(bcd_q);

  always_ff @(posedge clk) begin
    if (mr) begin
      state_q     <= StIdle;
      sh_q        <= '0;
      bcd_q       <= '0;
      co_s_q      <= 1'b0;
      cnt_q       <= '0;
      disp_bcd_q  <= '0;
      disp_co_q   <= 1'b0;
      conv_done_q <= 1'b0;
    end else begin
      conv_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          sh_q    <= q_in;
          bcd_q   <= '0;
          co_s_q  <= co_in;
          cnt_q   <= '0;
          state_q <= StShift;
        end
        StShift: begin
          {bcd_q, sh_q} <= {bcd_adj[10:0], sh_q, 1'b0};
          cnt_q         <= cnt_q + 3'd1;
          if (cnt_q == 3'(SHIFT_CNT - 1)) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          disp_bcd_q  <= bcd_q;
          disp_co_q   <= co_s_q;
          conv_done_q <= 1'b1;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Digit mux ahead of the single decoder; blanking suppresses leading zeros only.
  always_comb begin
    digit = 4'd0;
    blank = 1'b0;
    unique case (idx_q)
      2'd0: digit = disp_bcd_q[3:0];
      2'd1: begin
        digit = disp_bcd_q[7:4];
        blank = LZB && (disp_bcd_q[11:8] == 4'd0) && (disp_bcd_q[7:4] == 4'd0);
      end
      2'd2: begin
        digit = disp_bcd_q[11:8];
        blank = LZB && (disp_bcd_q[11:8] == 4'd0);
      end
      2'd3: begin
        digit = DIGIT_DASH;
        blank = !disp_co_q;
      end
      default: ;
    endcase
  end

  seg7_decode u_decode (
    .digit_i (digit),
    .blank_i (blank),
    .seg_o   (seg_d)
  );

  always_ff @(posedge clk) begin
    if (mr) begin
      pre_q     <= '0;
      idx_q     <= '0;
      seg_q     <= SEG_BLANK;
      dig_sel_q <= 4'b0000;
    end else begin
      if (pre_q == PreMax) begin
        pre_q <= '0;
        idx_q <= idx_q + 2'd1;
      end else begin
        pre_q <= pre_q + 1'b1;
      end
      seg_q     <= seg_d;
      dig_sel_q <= 4'b0001 << idx_q;
    end
  end

  assign seg       = seg_q;
  assign dig_sel   = dig_sel_q;
  assign conv_done = conv_done_q;

endmodule

// File: doc/bcd_seg_scan.md
# bcd_seg_scan

Downstream display stage for the 8-bit binary counter. Repeatedly samples the counter value `q_in` and carry `co_in`, and converts the value to three BCD digits with a sequential shift-add-3 (double-dabble) engine. The latched result drives a 4-digit multiplexed 7-segment display through a scan prescaler. Digits 0–2 show ones, tens and hundreds; digit 3 shows the carry indicator.

## Interface
- `SCAN_DIV`, 1000: clock cycles per digit slot; legal range ≥1.
- `LZB`, 1: leading-zero blanking enable (1 = blank).
- `clk`  in  1  system clock; all state updates on rising edge.
- `mr`  in  1  reset; synchronous, active-high.
- `q_in`  in  8  binary count from the counter.
- `co_in`  in  1  counter carry-out.
- `seg`  out  7  segment drive, active-high, bit order gfedcba (bit0 = a).
- `dig_sel`  out  4  one-hot digit enable, active-high; bit0 = ones.
- `conv_done`  out  1  one-cycle pulse when the display register updates.

## Operation
- Conversion FSM states: `IDLE`, `SHIFT`, `DONE`.
- `IDLE`:
  - load `sh <= q_in`, `bcd <= 12'h000`, `co_s <= co_in`, `cnt <= 0`
  - go to `SHIFT`.
- `SHIFT`, once per cycle:
  - add 3 to each BCD nibble that is ≥5
  - shift `{bcd, sh}` left by 1
  - `cnt++`
  - after the 8th shift, go to `DONE`.
- `DONE`:
  - `disp_bcd <= bcd`, `disp_co <= co_s`
  - `conv_done <= 1` for this cycle only
  - go to `IDLE`.
- `q_in`/`co_in` changes outside the `IDLE` sample cycle are ignored until the next sample.
- Scanner:
  - prescaler counts 0..`SCAN_DIV`-1
  - on wrap, digit index advances 0→1→2→3→0.
- Digit content:
  - index 0 = ones, 1 = tens, 2 = hundreds
  - index 3 = `7'h40` ('-') when `disp_co`=1, else `7'h00`.
- Segment codes, digits 0–9: 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F.
- Blanking (`LZB`=1):
  - hundreds blank (`7'h00`) when 0
  - tens blank when hundreds = 0 and tens = 0
  - ones never blanked.
  - `LZB`=0: all three digits always shown.
- Width rules:
  - BCD register is 12 bits.
  - Max input 255 gives 2/5/5; nibbles never exceed 9.

## Timing
- Reset (`mr`=1 at an edge), same edge:
  - FSM → `IDLE`, all registers cleared (`disp_bcd`=0, `disp_co`=0)
  - prescaler = 0, index = 0
  - outputs `seg`=`7'h00`, `dig_sel`=`4'b0000`, `conv_done`=0.
- `seg` and `dig_sel` are registered. From the first edge after reset release:
  - `dig_sel`=`4'b0001`
  - `seg` = decode of the current index, so `7'h3F` with `disp_bcd`=0.
- Conversion latency:
  - `q_in` sampled at edge k (`IDLE`)
  - shifts at edges k+1..k+8
  - `disp_bcd` and `conv_done` updated at edge k+9
  - next sample at edge k+10, so the refresh period is 10 cycles.
- Digit switching: `dig_sel` changes exactly every `SCAN_DIV` cycles. With `SCAN_DIV`=1 it advances every cycle.
- `dig_sel` and `seg` change on the same edge; there is never a cycle with two digits enabled.
- `disp_bcd` update mid-slot: `seg` reflects the new value one edge later. The slot is not restarted.
- Reset mid-conversion: conversion aborted, display shows 0, and a fresh conversion starts from `IDLE`.

## Structure
- Shared package `bcd_seg_pkg`:
  - FSM state enum
  - segment constants for digits 0–9, dash (`7'h40`) and blank (`7'h00`)
  - `SHIFT_CNT`=8.
- Sub-module `seg7_decode`: combinational 4-bit digit + blank flag → 7-bit `seg`; instantiated once, after the digit mux.
- Top: FSM/double-dabble datapath, display registers, prescaler, index counter, blanking logic, output registers.

## Test plan
- Reset, then hold `q_in`=0, `SCAN_DIV`=4 → `dig_sel` cycles 0001, 0010, 0100, 1000 every 4 cycles; `seg` shows 3F on ones and 00 on the other three digits (`LZB`=1).
- `q_in`=8'd255, `co_in`=1 → `conv_done` 9 cycles after the sample; digits show 5 (6D), 5 (6D), 2 (5B), and 40 on digit 3.
- `q_in`=8'd7 with `LZB`=1 → ones 07, tens and hundreds 00. With `LZB`=0 → tens and hundreds 3F.
- `q_in` changed from 100 to 99 during `SHIFT` → display shows 100 (ones 3F, tens 3F, hundreds 06); the next conversion shows 99 (6F, 6F, 00).
- Assert `mr` at the 5th `SHIFT` cycle of converting 200 → next edge: `seg`=00, `dig_sel`=0000, no `conv_done`; after release the display shows the freshly sampled value.
- `SCAN_DIV`=1 with counter ramp 0..255 → `conv_done` pulses every 10 cycles; each `disp_bcd` equals the decimal of the sampled value.
